// File: rtl/channelizer_bin_select_if.sv
// AXI-stream style handshake bundle for the channelizer bin selector.
// master drives data/user/last/valid, slave drives ready.
interface channelizer_bin_select_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic [15:0]       tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/channelizer_bin_select.sv
// Keeps mask-selected bins of bin-interleaved frames, tags them with the bin index and re-packetises to SPP.
// Define CHAN_SEL_STATS_EN to build the saturating drop / sync-error counters (tied to 0 otherwise).
module channelizer_bin_select #(
  parameter int NUM_CHANNELS = 256,
  parameter int DATA_W       = 32,
  parameter int SR_BASE      = 160
) (
  input  logic                     ce_clk,
  input  logic                     ce_rst,
  input  logic                     set_stb,
  input  logic [7:0]               set_addr,
  input  logic [31:0]              set_data,
  channelizer_bin_select_if.slave  inBus,
  channelizer_bin_select_if.master outBus,
  output logic                     sync_err,
  output logic [31:0]              stat_dropped,
  output logic [15:0]              stat_sync_err
);
  localparam int NW      = NUM_CHANNELS / 32;
  localparam int BIN_W   = $clog2(NUM_CHANNELS);
  localparam int SR_SPP  = SR_BASE + NW;
  localparam int SR_CTRL = SR_BASE + NW + 1;
  localparam int EW      = DATA_W + 17;

  logic [NUM_CHANNELS-1:0] r_shadowMask;
  logic [NUM_CHANNELS-1:0] r_activeMask;
  logic                    r_enable;
  logic                    r_readyEn;
  logic [11:0]             r_sppPending;
  logic [11:0]             r_spp;
  logic [BIN_W-1:0]        r_binCnt;
  logic [11:0]             r_pktCnt;
  logic                    r_syncErr;
  logic [1:0]              r_count;
  logic [EW-1:0]           r_ent0;
  logic [EW-1:0]           r_ent1;

  int                      w_addrOff;
  logic [NUM_CHANNELS-1:0] w_shadowNext;
  logic                    w_sppWr;
  logic                    w_ctrlWr;
  logic                    w_resync;
  logic [11:0]             w_sppClamped;
  logic                    w_inFire;
  logic                    w_lastBin;
  logic                    w_wrap;
  logic                    w_syncEvt;
  logic                    w_keep;
  logic                    w_pop;
  logic [11:0]             w_sppEff;
  logic                    w_pktEnd;
  logic [15:0]             w_binTag;
  logic [EW-1:0]           w_newEntry;
  logic                    w_unused;

  assign w_addrOff    = int'(set_addr) - SR_BASE;
  assign w_sppWr      = set_stb && (int'(set_addr) == SR_SPP);
  assign w_ctrlWr     = set_stb && (int'(set_addr) == SR_CTRL);
  assign w_resync     = w_ctrlWr & set_data[1];
  assign w_sppClamped = (set_data[11:0] == 12'd0) ? 12'd1 : set_data[11:0];

  // Shadow value including this cycle's write, so a write coinciding with a wrap lands in the copy.
  always_comb begin
    w_shadowNext = r_shadowMask;
    for (int k = 0; k < NW; k++) begin
      if (set_stb && (w_addrOff == k)) begin
        w_shadowNext[32*k +: 32] = set_data;
      end
    end
  end

  assign w_inFire  = inBus.tvalid & inBus.tready;
  assign w_lastBin = (r_binCnt == BIN_W'(NUM_CHANNELS - 1));
  assign w_wrap    = w_inFire & (inBus.tlast | w_lastBin);
  assign w_syncEvt = w_inFire & (inBus.tlast ^ w_lastBin);
  assign w_keep    = w_inFire & r_enable & r_activeMask[r_binCnt] & ~w_resync;
  assign w_pop     = (r_count != 2'd0) & outBus.tready;

  // A pending SPP applies to the first sample of a new packet.
  assign w_sppEff   = (r_pktCnt == 12'd0) ? r_sppPending : r_spp;
  assign w_pktEnd   = ((r_pktCnt + 12'd1) == w_sppEff);
  assign w_binTag   = {{(16 - BIN_W){1'b0}}, r_binCnt};
  assign w_newEntry = {inBus.tdata, w_binTag, w_pktEnd};

  assign inBus.tready = r_readyEn & (r_count != 2'd2);
  assign outBus.tvalid = (r_count != 2'd0);
  assign {outBus.tdata, outBus.tuser, outBus.tlast} = r_ent0;
  assign sync_err = r_syncErr;
  assign w_unused = ^inBus.tuser;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_readyEn    <= 1'b0;
      r_shadowMask <= '0;
      r_activeMask <= '0;
      r_enable     <= 1'b0;
      r_sppPending <= 12'd64;
      r_spp        <= 12'd64;
      r_binCnt     <= '0;
      r_pktCnt     <= '0;
      r_syncErr    <= 1'b0;
    end else begin
      r_readyEn    <= 1'b1;
      r_shadowMask <= w_shadowNext;
      r_syncErr    <= w_syncEvt & ~w_resync;
      if (w_sppWr) begin
        r_sppPending <= w_sppClamped;
      end
      if (r_pktCnt == 12'd0) begin
        r_spp <= r_sppPending;
      end
      if (w_ctrlWr) begin
        r_enable <= set_data[0];
      end
      if (w_resync) begin
        r_binCnt     <= '0;
        r_pktCnt     <= '0;
        r_activeMask <= w_shadowNext;
      end else begin
        if (w_wrap) begin
          r_binCnt     <= '0;
          r_activeMask <= w_shadowNext;
        end else if (w_inFire) begin
          r_binCnt <= r_binCnt + BIN_W'(1);
        end
        if (w_keep) begin
          r_pktCnt <= w_pktEnd ? 12'd0 : (r_pktCnt + 12'd1);
        end
      end
    end
  end

  // Two-entry skid: r_ent0 is the presented head, r_ent1 catches one sample during a stall.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_count <= 2'd0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else if (w_resync) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_keep, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_ent0 <= w_newEntry;
          end else begin
            r_ent1 <= w_newEntry;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0 <= w_newEntry;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_newEntry;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHAN_SEL_STATS_EN
  logic [31:0] r_statDropped;
  logic [15:0] r_statSync;
  logic        w_drop;

  assign w_drop = w_inFire & ~w_keep;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_statDropped <= '0;
      r_statSync    <= '0;
    end else if (w_resync) begin
      r_statDropped <= '0;
      r_statSync    <= '0;
    end else begin
      if (w_drop && (r_statDropped != '1)) begin
        r_statDropped <= r_statDropped + 32'd1;
      end
      if (w_syncEvt && (r_statSync != '1)) begin
        r_statSync <= r_statSync + 16'd1;
      end
    end
  end

  assign stat_dropped  = r_statDropped;
  assign stat_sync_err = r_statSync;
`else
  assign stat_dropped  = '0;
  assign stat_sync_err = '0;
`endif

endmodule
